// File: rtl/gate_check_pkg.sv
// Shared constants for the gate response checker: FSM encodings, truth tables, payload width.
package gate_check_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Expected y indexed by {a,b}: bit0 = 00 .. bit3 = 11
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Delay-line payload {valid, a, b}
  localparam int unsigned VEC_W = 3;

  // Expected gate output for vector {a,b}
  function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/vec_delay_line.sv
// Fixed-depth shift register of {valid,a,b}; DEPTH=0 is a wire.
module vec_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             tail_empty_c
);

  if (DEPTH == 0) begin : g_pass
    assign out_data     = in_data;
    assign tail_empty_c = 1'b1;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             pending;

    // Shift one stage per cycle; flush drops everything in flight
    always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
      if (!flush) begin
        stage_d[0] = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    // Stage registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    // Nothing valid behind the output stage: current output is the last pending entry
    always_comb begin
      pending = 1'b0;
      for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | stage_q[i][WIDTH-1];
    end

    assign out_data     = stage_q[DEPTH-1];
    assign tail_empty_c = !pending;
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response analyzer for 2-input gate tests: delays applied vectors, compares DUT y
// against a truth table, counts mismatches, tracks coverage, reports pass at end of run.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_NAND,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       coverage,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
);

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       coverage_q, coverage_d;
  logic             fe_valid_q, fe_valid_d;
  logic [1:0]       fe_vec_q, fe_vec_d;

  logic             start_ok_c;
  logic             accept_c;
  logic             check_c;
  logic             mismatch_c;
  logic [VEC_W-1:0] dly_in;
  logic [VEC_W-1:0] dly_out;
  logic             tail_empty_c;
  logic [1:0]       chk_vec;

  assign start_ok_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept_c   = vec_valid && (state_q == S_RUN);
  assign dly_in     = {accept_c, vec_a, vec_b};
  assign chk_vec    = dly_out[1:0];
  assign check_c    = dly_out[VEC_W-1] && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign mismatch_c = check_c && (dut_y != tt_lookup(TRUTH_TABLE, chk_vec));

  vec_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (VEC_W)
  ) u_dly (
    .clk          (clk),
    .rst          (rst),
    .flush        (start_ok_c),
    .in_data      (dly_in),
    .out_data     (dly_out),
    .tail_empty_c (tail_empty_c)
  );

  // Next state, counters, coverage and first-error capture
  always_comb begin
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    coverage_d = coverage_q;
    fe_valid_d = fe_valid_q;
    fe_vec_d   = fe_vec_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE:  if (start_ok_c) state_d = S_RUN;
      S_RUN:   if (accept_c && vec_last) state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (tail_empty_c) state_d = S_DONE;
      S_DONE:  if (start_ok_c) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (start_ok_c) begin
      err_cnt_d  = '0;
      coverage_d = '0;
      fe_valid_d = 1'b0;
      fe_vec_d   = '0;
      pass_d     = 1'b0;
    end else if (check_c) begin
      coverage_d[chk_vec] = 1'b1;
      if (mismatch_c) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        if (!fe_valid_q) begin
          fe_valid_d = 1'b1;
          fe_vec_d   = chk_vec;
        end
      end
    end

    // Verdict includes the final check, lands on the same edge done rises
    if ((state_d == S_DONE) && (state_q != S_DONE))
      pass_d = (err_cnt_d == '0) && (coverage_d == 4'hF);

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      coverage_q <= '0;
      fe_valid_q <= 1'b0;
      fe_vec_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      coverage_q <= coverage_d;
      fe_valid_q <= fe_valid_d;
      fe_vec_q   <= fe_vec_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign coverage        = coverage_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: four checker builds (L1/ERR_W8, L1/ERR_W2, L0, L4) share one stimulus
// stream; each gets y from a small gate model with matching latency and selectable fault.
module tb_gate_response_checker;
  import gate_check_pkg::*;

  logic clk = 1'b0;
  logic rst, start, vec_valid, vec_last, vec_a, vec_b;
  int   fault;     // 0 good NAND, 1 stuck-at-1, 2 inverted
  int   n_vec  = 0;
  int   n_fail = 0;

  logic [1:0] hist [4];
  logic y_l0, y_l1, y_l4;

  logic       d_busy, d_done, d_pass, d_fev;
  logic [7:0] d_err;
  logic [3:0] d_cov;
  logic [1:0] d_fvec;
  logic       s_busy, s_done, s_pass, s_fev;
  logic [1:0] s_err;
  logic [3:0] s_cov;
  logic [1:0] s_fvec;
  logic       z_busy, z_done, z_pass, z_fev;
  logic [7:0] z_err;
  logic [3:0] z_cov;
  logic [1:0] z_fvec;
  logic       f_busy, f_done, f_pass, f_fev;
  logic [7:0] f_err;
  logic [3:0] f_cov;
  logic [1:0] f_fvec;

  always #5 clk = ~clk;

  function automatic logic gate_model(input logic [1:0] v, input int mode);
    case (mode)
      0:       return ~(v[1] & v[0]);
      1:       return 1'b1;
      default: return v[1] & v[0];
    endcase
  endfunction

  // History of applied vectors: hist[k] is the vector from k+1 cycles ago
  always @(posedge clk) begin
    hist[0] <= {vec_a, vec_b};
    for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
  end

  assign y_l0 = gate_model({vec_a, vec_b}, fault);
  assign y_l1 = gate_model(hist[0], fault);
  assign y_l4 = gate_model(hist[3], fault);

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .LATENCY(1), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_y(y_l1), .busy(d_busy), .done(d_done),
    .pass(d_pass), .err_cnt(d_err), .coverage(d_cov), .first_err_valid(d_fev),
    .first_err_vec(d_fvec));

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .LATENCY(1), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_y(y_l1), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_cnt(s_err), .coverage(s_cov), .first_err_valid(s_fev),
    .first_err_vec(s_fvec));

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .LATENCY(0), .ERR_W(8)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_y(y_l0), .busy(z_busy), .done(z_done),
    .pass(z_pass), .err_cnt(z_err), .coverage(z_cov), .first_err_valid(z_fev),
    .first_err_vec(z_fvec));

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .LATENCY(4), .ERR_W(8)) u_l4 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
    .vec_a(vec_a), .vec_b(vec_b), .dut_y(y_l4), .busy(f_busy), .done(f_done),
    .pass(f_pass), .err_cnt(f_err), .coverage(f_cov), .first_err_valid(f_fev),
    .first_err_vec(f_fvec));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic a, input logic b, input logic last);
    vec_valid = 1'b1;
    vec_a     = a;
    vec_b     = b;
    vec_last  = last;
    tick();
    vec_valid = 1'b0;
    vec_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic full_sweep();
    send(0, 0, 0); send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    vec_a = 1'b0; vec_b = 1'b0; fault = 0;
    repeat (3) tick();
    chk("rst_busy", 32'(d_busy), 0);
    chk("rst_done", 32'(d_done), 0);
    chk("rst_pass", 32'(d_pass), 0);
    chk("rst_err",  32'(d_err), 0);
    chk("rst_cov",  32'(d_cov), 0);
    chk("rst_fev",  32'(d_fev), 0);
    rst = 1'b0;
    tick();

    // Vectors in IDLE are ignored
    fault = 2;
    send(0, 0, 1); send(1, 1, 1);
    repeat (3) tick();
    chk("idle_err",  32'(d_err), 0);
    chk("idle_cov",  32'(d_cov), 0);
    chk("idle_busy", 32'(d_busy), 0);
    chk("idle_l0_done", 32'(z_done), 0);
    fault = 0;

    // 1: good NAND sweep, LATENCY=1
    pulse_start();
    chk("t1_busy", 32'(d_busy), 1);
    full_sweep();
    chk("t1_done_early", 32'(d_done), 0);
    chk("t1_drain_busy", 32'(d_busy), 1);
    tick();
    chk("t1_done", 32'(d_done), 1);
    chk("t1_busy_lo", 32'(d_busy), 0);
    chk("t1_err",  32'(d_err), 0);
    chk("t1_cov",  32'(d_cov), 32'hF);
    chk("t1_pass", 32'(d_pass), 1);
    chk("t1_fev",  32'(d_fev), 0);
    repeat (6) tick();

    // Vectors in DONE are ignored, results hold
    fault = 2;
    send(1, 1, 1);
    tick();
    chk("done_hold_err",  32'(d_err), 0);
    chk("done_hold_pass", 32'(d_pass), 1);
    chk("done_hold_done", 32'(d_done), 1);
    fault = 0;

    // 2: stuck-at-1 DUT fails only on 11
    fault = 1;
    pulse_start();
    full_sweep();
    tick();
    chk("t2_err",  32'(d_err), 1);
    chk("t2_fev",  32'(d_fev), 1);
    chk("t2_fvec", 32'(d_fvec), 32'h3);
    chk("t2_pass", 32'(d_pass), 0);
    chk("t2_cov",  32'(d_cov), 32'hF);
    repeat (6) tick();

    // 3: incomplete coverage
    fault = 0;
    pulse_start();
    send(0, 0, 0); send(0, 1, 0); send(1, 0, 1);
    tick();
    chk("t3_done", 32'(d_done), 1);
    chk("t3_err",  32'(d_err), 0);
    chk("t3_cov",  32'(d_cov), 32'h7);
    chk("t3_pass", 32'(d_pass), 0);
    chk("t3_fev_clr", 32'(d_fev), 0);
    repeat (6) tick();

    // 4: saturation on ERR_W=2 build, six mismatches
    fault = 2;
    pulse_start();
    send(1, 0, 0); send(0, 1, 0); send(1, 1, 0); send(0, 0, 0); send(1, 0, 0); send(0, 1, 1);
    tick();
    chk("t4_sat_err",  32'(s_err), 3);
    chk("t4_sat_fev",  32'(s_fev), 1);
    chk("t4_sat_fvec", 32'(s_fvec), 32'h2);
    chk("t4_sat_pass", 32'(s_pass), 0);
    chk("t4_wide_err", 32'(d_err), 6);
    repeat (6) tick();

    // 5: async reset mid-run, then clean run with an ignored start in RUN
    fault = 0;
    pulse_start();
    send(0, 0, 0); send(0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(d_busy), 0);
    chk("t5_rst_cov",  32'(d_cov), 0);
    chk("t5_rst_done", 32'(d_done), 0);
    chk("t5_rst_l4_busy", 32'(f_busy), 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    send(0, 0, 0);
    start = 1'b1;
    send(0, 1, 0);
    start = 1'b0;
    send(1, 0, 0); send(1, 1, 1);
    tick();
    chk("t5_done", 32'(d_done), 1);
    chk("t5_cov",  32'(d_cov), 32'hF);
    chk("t5_err",  32'(d_err), 0);
    chk("t5_pass", 32'(d_pass), 1);
    repeat (6) tick();

    // 6: LATENCY 0 and 4 with gaps in vec_valid
    pulse_start();
    send(0, 0, 0); tick();
    send(0, 1, 0); tick(); tick();
    send(1, 0, 0); send(1, 1, 1);
    chk("t6_l0_done", 32'(z_done), 1);
    chk("t6_l0_pass", 32'(z_pass), 1);
    chk("t6_l0_cov",  32'(z_cov), 32'hF);
    chk("t6_l4_done0", 32'(f_done), 0);
    repeat (3) tick();
    chk("t6_l4_done3", 32'(f_done), 0);
    chk("t6_l4_busy3", 32'(f_busy), 1);
    tick();
    chk("t6_l4_done", 32'(f_done), 1);
    chk("t6_l4_pass", 32'(f_pass), 1);
    chk("t6_l4_err",  32'(f_err), 0);
    chk("t6_l4_cov",  32'(f_cov), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
